pixel_frame_controller: RTL and testbench

Frame-sequencing state machine that drives the shared control bus of the pixel array. Generates the ERASE, EXPOSE, CONVERT and row-wise READ phases plus the 8-bit ADC COUNTER that every pixel row consumes. It sits directly upstream of the pixel rows; its outputs fan out unchanged to all rows, except READ, which is one-hot per row.

---
 rtl/pixel_frame_controller.sv | 123 ++++++++++++
 tb/tb_pixel_frame_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_controller.sv
// Frame sequencer for the pixel array: ERASE -> EXPOSE -> CONVERT -> row-wise READ.
// Every output is a flop loaded from the next-state decode, so nothing downstream sees decode glitches.
module pixel_frame_controller #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int READ_CYCLES   = 5,
  parameter int NUM_ROWS      = 2,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                START,
  output logic                ERASE,
  output logic                PIXEL_RESET,
  output logic                EXPOSE,
  output logic                CONVERT,
  output logic [7:0]          COUNTER,
  output logic [NUM_ROWS-1:0] READ,
  output logic [RW-1:0]       ROW_SEL,
  output logic                FRAME_DONE
);

  // state   | meaning
  // IDLE    | waiting for START, all phase outputs low
  // ERASE   | pixel erase + latch reset, COUNTER cleared on entry
  // EXPOSE  | exposure window
  // CONVERT | ramp running, COUNTER sweeps 0..255
  // READ    | one row enabled at a time, rows 0..NUM_ROWS-1

  localparam int MAX_A = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_B = (READ_CYCLES > 256) ? READ_CYCLES : 256;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PW    = $clog2(MAX_C);

  localparam logic [PW-1:0]       ERASE_LAST   = PW'(ERASE_CYCLES - 1);
  localparam logic [PW-1:0]       EXPOSE_LAST  = PW'(EXPOSE_CYCLES - 1);
  localparam logic [PW-1:0]       CONVERT_LAST = PW'(255);
  localparam logic [PW-1:0]       READ_LAST    = PW'(READ_CYCLES - 1);
  localparam logic [RW-1:0]       LAST_ROW     = RW'(NUM_ROWS - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE      = NUM_ROWS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [7:0]    count_nxt;
  logic          done_nxt;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + 1'b1;
    row_nxt   = row;
    count_nxt = COUNTER;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        if (START) state_nxt = S_ERASE;
      end
      S_ERASE:  if (phase == ERASE_LAST)  state_nxt = S_EXPOSE;
      S_EXPOSE: if (phase == EXPOSE_LAST) state_nxt = S_CONVERT;
      S_CONVERT: begin
        // The last CONVERT cycle holds 255 instead of wrapping.
        if (phase == CONVERT_LAST) begin
          state_nxt = S_READ;
          row_nxt   = '0;
        end else begin
          count_nxt = COUNTER + 8'd1;
        end
      end
      S_READ: begin
        if (phase == READ_LAST) begin
          if (row == LAST_ROW) begin
            done_nxt  = 1'b1;
            state_nxt = START ? S_ERASE : S_IDLE;
          end else begin
            row_nxt   = row + 1'b1;
            phase_nxt = '0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) phase_nxt = '0;
    if (state_nxt == S_ERASE && state != S_ERASE) count_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      row         <= '0;
      COUNTER     <= '0;
      ERASE       <= 1'b0;
      PIXEL_RESET <= 1'b0;
      EXPOSE      <= 1'b0;
      CONVERT     <= 1'b0;
      READ        <= '0;
      ROW_SEL     <= '0;
      FRAME_DONE  <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      row         <= row_nxt;
      COUNTER     <= count_nxt;
      ERASE       <= (state_nxt == S_ERASE);
      PIXEL_RESET <= (state_nxt == S_ERASE);
      EXPOSE      <= (state_nxt == S_EXPOSE);
      CONVERT     <= (state_nxt == S_CONVERT);
      READ        <= (state_nxt == S_READ) ? (ROW_ONE << row_nxt) : '0;
      ROW_SEL     <= (state_nxt == S_READ) ? row_nxt : '0;
      FRAME_DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_frame_controller.sv
// Bench for pixel_frame_controller: a 5/10/5/2 instance for the main scenarios and a 1/1/1/1 instance
// for the minimum-parameter case. Expected per-cycle output vectors are built from the frame timeline.
module tb_pixel_frame_controller;

  localparam int E = 5, X = 10, R = 5, N = 2;
  localparam int L = E + X + 256 + N * R;

  logic clk, reset, start_a, start_b;

  logic       erase_a, prst_a, expose_a, convert_a, done_a, row_sel_a;
  logic [7:0] counter_a;
  logic [1:0] read_a;

  logic       erase_b, prst_b, expose_b, convert_b, done_b, row_sel_b;
  logic [7:0] counter_b;
  logic [0:0] read_b;

  logic [15:0] obs_a, obs_b;
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  pixel_frame_controller #(
    .ERASE_CYCLES(E), .EXPOSE_CYCLES(X), .READ_CYCLES(R), .NUM_ROWS(N)
  ) dut_a (
    .clk(clk), .reset(reset), .START(start_a), .ERASE(erase_a), .PIXEL_RESET(prst_a),
    .EXPOSE(expose_a), .CONVERT(convert_a), .COUNTER(counter_a), .READ(read_a),
    .ROW_SEL(row_sel_a), .FRAME_DONE(done_a)
  );

  pixel_frame_controller #(
    .ERASE_CYCLES(1), .EXPOSE_CYCLES(1), .READ_CYCLES(1), .NUM_ROWS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .START(start_b), .ERASE(erase_b), .PIXEL_RESET(prst_b),
    .EXPOSE(expose_b), .CONVERT(convert_b), .COUNTER(counter_b), .READ(read_b),
    .ROW_SEL(row_sel_b), .FRAME_DONE(done_b)
  );

  assign obs_a = {erase_a, prst_a, expose_a, convert_a, counter_a, read_a, row_sel_a, done_a};
  assign obs_b = {erase_b, prst_b, expose_b, convert_b, counter_b, 1'b0, read_b, row_sel_b, done_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: erase, pixel_reset, expose, convert, counter[7:0], read[1:0], row_sel, frame_done.
  function automatic logic [15:0] frame_vec(int k, int ec, int xc, int rc);
    logic       e, x, c, rs;
    logic [7:0] cnt;
    logic [1:0] rd;
    int         j;
    e = 0; x = 0; c = 0; rs = 0; cnt = 8'd0; rd = 2'b00;
    if (k < ec) e = 1;
    else if (k < ec + xc) x = 1;
    else if (k < ec + xc + 256) begin
      c   = 1;
      cnt = 8'(k - ec - xc);
    end else begin
      j   = (k - ec - xc - 256) / rc;
      rd  = 2'(1 << j);
      rs  = 1'(j);
      cnt = 8'd255;
    end
    return {e, e, x, c, cnt, rd, rs, 1'b0};
  endfunction

  function automatic void push_frame(int ec, int xc, int rc, int nr, bit prev_done);
    logic [15:0] v;
    for (int k = 0; k < ec + xc + 256 + nr * rc; k++) begin
      v = frame_vec(k, ec, xc, rc);
      if (k == 0) v[0] = prev_done;
      exp_q.push_back(v);
    end
  endfunction

  function automatic void push_idle(int n, logic [7:0] cnt, bit done_first);
    for (int k = 0; k < n; k++)
      exp_q.push_back({4'b0, cnt, 3'b0, (done_first && k == 0)});
  endfunction

  task automatic test_reset();
    logic [15:0] ev;
    int i;
    start_a = 1;
    for (i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs_a !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: got %h want 0000", i, obs_a);
      end
    end
    @(negedge clk) reset = 1;
    push_frame(E, X, R, N, 0);
    push_idle(2, 8'd255, 1);
    i = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL reset_release cyc %0d: got %h want %h", i, obs_a, ev);
      end
      if (i == 0) start_a = 0;
      i++;
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] ev;
    int i = 0;
    start_a = 1;
    push_frame(E, X, R, N, 0);
    push_idle(3, 8'd255, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL single_frame cyc %0d: got %h want %h", i, obs_a, ev);
      end
      if (i == 0) start_a = 0;
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ev;
    int i = 0;
    start_a = 1;
    push_frame(E, X, R, N, 0);
    push_frame(E, X, R, N, 1);
    push_idle(2, 8'd255, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs_a, ev);
      end
      if (i == L) start_a = 0;
      i++;
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [15:0] ev;
    int i = 0;
    start_a = 1;
    push_frame(E, X, R, N, 0);
    while (i < E + X + 101) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL mid_convert_run cyc %0d: got %h want %h", i, obs_a, ev);
      end
      if (i == 0) start_a = 0;
      i++;
    end
    exp_q.delete();
    #3 reset = 0;
    #1;
    n_cmp++;
    if (obs_a !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0000", obs_a);
    end
    @(posedge clk);
    @(negedge clk) reset = 1;
    push_idle(6, 8'd0, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL post_reset_idle cyc %0d: got %h want %h", i, obs_a, ev);
      end
      i++;
    end
  endtask

  task automatic test_start_drop_in_expose();
    logic [15:0] ev;
    int i = 0;
    start_a = 1;
    push_frame(E, X, R, N, 0);
    push_idle(4, 8'd255, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_a !== ev) begin
        n_bad++;
        $display("FAIL start_drop cyc %0d: got %h want %h", i, obs_a, ev);
      end
      if (i == E + 3) start_a = 0;
      i++;
    end
  endtask

  task automatic test_edge_params();
    logic [15:0] ev;
    logic [3:0]  ph;
    int i = 0;
    int done_idx = -1;
    start_b = 1;
    push_frame(1, 1, 1, 1, 0);
    push_idle(3, 8'd255, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      n_cmp++;
      if (obs_b !== ev) begin
        n_bad++;
        $display("FAIL edge_params cyc %0d: got %h want %h", i, obs_b, ev);
      end
      ph = {erase_b, expose_b, convert_b, read_b[0]};
      n_cmp++;
      if (!$onehot0(ph)) begin
        n_bad++;
        $display("FAIL edge_exclusive cyc %0d: phases %b want at most one high", i, ph);
      end
      if (done_b === 1'b1 && done_idx < 0) done_idx = i;
      if (i == 0) start_b = 0;
      i++;
    end
    n_cmp++;
    if (done_idx !== 259) begin
      n_bad++;
      $display("FAIL edge_frame_len: got %0d want 259", done_idx);
    end
  endtask

  initial begin
    reset   = 0;
    start_a = 0;
    start_b = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_convert();
    test_start_drop_in_expose();
    test_edge_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
